// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the processor-memory bus arbiter: bus commands, tag-table
// entry layout and widths.
package mem_bus_arbiter_pkg;

  localparam int unsigned SYS_XLEN     = 32;
  localparam int unsigned MEM_DATA_W   = 64;
  localparam int unsigned MEM_TAG_W    = 4;
  localparam int unsigned MEM_NUM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    OWN_NONE = 2'h0,
    OWN_IC   = 2'h1,
    OWN_DC   = 2'h2
  } MEM_OWNER;

  typedef struct packed {
    MEM_OWNER owner;
    logic     stale;
  } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request, memory-bus and fill signals of the arbiter. The slave modport is the
// arbiter; the master modport is the cache/memory side that drives it.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic                   ic_req;
  logic [SYS_XLEN-1:0]    ic_addr;
  logic                   ic_squash;
  logic                   dc_req;
  BUS_COMMAND             dc_cmd;
  logic [SYS_XLEN-1:0]    dc_addr;
  logic [MEM_DATA_W-1:0]  dc_wdata;

  BUS_COMMAND             proc2mem_command;
  logic [SYS_XLEN-1:0]    proc2mem_addr;
  logic [MEM_DATA_W-1:0]  proc2mem_data;
  logic [MEM_TAG_W-1:0]   mem2proc_response;
  logic [MEM_DATA_W-1:0]  mem2proc_data;
  logic [MEM_TAG_W-1:0]   mem2proc_tag;

  logic                   ic_grant;
  logic                   dc_grant;
  logic [MEM_TAG_W-1:0]   grant_tag;
  logic                   ic_resp_valid;
  logic [MEM_DATA_W-1:0]  ic_resp_data;
  logic [MEM_TAG_W-1:0]   ic_resp_tag;
  logic                   dc_resp_valid;
  logic [MEM_DATA_W-1:0]  dc_resp_data;
  logic [MEM_TAG_W-1:0]   dc_resp_tag;
  logic [MEM_TAG_W-1:0]   ic_outstanding;

  modport slave (
    input  ic_req, ic_addr, ic_squash, dc_req, dc_cmd, dc_addr, dc_wdata,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output ic_grant, dc_grant, grant_tag,
    output ic_resp_valid, ic_resp_data, ic_resp_tag,
    output dc_resp_valid, dc_resp_data, dc_resp_tag,
    output ic_outstanding
  );

  modport master (
    output ic_req, ic_addr, ic_squash, dc_req, dc_cmd, dc_addr, dc_wdata,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  ic_grant, dc_grant, grant_tag,
    input  ic_resp_valid, ic_resp_data, ic_resp_tag,
    input  dc_resp_valid, dc_resp_data, dc_resp_tag,
    input  ic_outstanding
  );

endinterface

// File: rtl/mem_tag_table.sv
// Memory tag ownership table: records which cache owns each in-flight tag and
// whether an icache fetch has been made stale by a redirect.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_TAGS = MEM_NUM_TAGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en_i,
  input  logic [MEM_TAG_W-1:0] alloc_tag_i,
  input  MEM_OWNER             alloc_owner_i,
  input  logic                 free_en_i,
  input  logic [MEM_TAG_W-1:0] free_tag_i,
  input  logic                 squash_i,
  output MEM_TAG_ENTRY         lookup_o,
  output logic [MEM_TAG_W-1:0] ic_outstanding_o
);

  localparam int unsigned DEPTH = 2 ** MEM_TAG_W;

  if (NUM_TAGS < 2 || NUM_TAGS > DEPTH) begin : g_bad_num_tags
    $error("NUM_TAGS must be between 2 and 16");
  end

  MEM_TAG_ENTRY         tab_q [DEPTH];
  MEM_TAG_ENTRY         tab_d [DEPTH];
  logic [MEM_TAG_W-1:0] outst_q, outst_d;

  assign lookup_o         = tab_q[free_tag_i];
  assign ic_outstanding_o = outst_q;

  // Squash, then free, then allocate: a same-cycle allocation always survives.
  always_comb begin
    tab_d   = tab_q;
    outst_d = '0;
    if (squash_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (tab_q[MEM_TAG_W'(i)].owner == OWN_IC) tab_d[MEM_TAG_W'(i)].stale = 1'b1;
      end
    end
    if (free_en_i) tab_d[free_tag_i] = '{owner: OWN_NONE, stale: 1'b0};
    if (alloc_en_i && alloc_tag_i != '0 && 32'(alloc_tag_i) < NUM_TAGS) begin
      tab_d[alloc_tag_i] = '{owner: alloc_owner_i, stale: 1'b0};
    end
    for (int unsigned i = 1; i < NUM_TAGS; i++) begin
      if (tab_d[MEM_TAG_W'(i)].owner == OWN_IC && !tab_d[MEM_TAG_W'(i)].stale) begin
        outst_d = outst_d + MEM_TAG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tab_q[MEM_TAG_W'(i)] <= '{owner: OWN_NONE, stale: 1'b0};
      end
      outst_q <= '0;
    end else begin
      tab_q   <= tab_d;
      outst_q <= outst_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the memory bus between icache misses and dcache requests and routes
// tagged returns to their owner. MEM_ARB_STARVE_GUARD_EN enables icache anti-starvation.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned NUM_TAGS     = MEM_NUM_TAGS
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  if (STARVE_LIMIT == 0) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic         ic_elig_c;
  logic         ic_win_c;
  logic         dc_win_c;
  logic         accept_c;
  logic         ic_grant_c;
  logic         dc_grant_c;
  logic         ret_c;
  logic         force_ic_c;
  logic         alloc_en_c;
  MEM_OWNER     alloc_owner_c;
  MEM_TAG_ENTRY lookup_c;

  always_comb begin
    ic_elig_c             = bus.ic_req && !bus.ic_squash;
    ic_win_c              = ic_elig_c && (!bus.dc_req || force_ic_c);
    dc_win_c              = bus.dc_req && !ic_win_c;
    accept_c              = bus.mem2proc_response != '0;
    bus.proc2mem_command  = BUS_NONE;
    bus.proc2mem_addr     = '0;
    bus.proc2mem_data     = '0;
    if (ic_win_c) begin
      bus.proc2mem_command = BUS_LOAD;
      bus.proc2mem_addr    = bus.ic_addr;
    end else if (dc_win_c) begin
      bus.proc2mem_command = bus.dc_cmd;
      bus.proc2mem_addr    = bus.dc_addr;
      bus.proc2mem_data    = bus.dc_wdata;
    end
    ic_grant_c    = ic_win_c && accept_c;
    dc_grant_c    = dc_win_c && accept_c;
    bus.ic_grant  = ic_grant_c;
    bus.dc_grant  = dc_grant_c;
    bus.grant_tag = (ic_grant_c || dc_grant_c) ? bus.mem2proc_response : '0;
    alloc_en_c    = ic_grant_c || (dc_grant_c && bus.dc_cmd == BUS_LOAD);
    alloc_owner_c = ic_grant_c ? OWN_IC : OWN_DC;

    // Stale or squashed icache returns are dropped so old lines never fill.
    ret_c             = bus.mem2proc_tag != '0;
    bus.dc_resp_valid = ret_c && lookup_c.owner == OWN_DC;
    bus.ic_resp_valid = ret_c && lookup_c.owner == OWN_IC && !lookup_c.stale && !bus.ic_squash;
    bus.dc_resp_data  = bus.dc_resp_valid ? bus.mem2proc_data : '0;
    bus.dc_resp_tag   = bus.dc_resp_valid ? bus.mem2proc_tag  : '0;
    bus.ic_resp_data  = bus.ic_resp_valid ? bus.mem2proc_data : '0;
    bus.ic_resp_tag   = bus.ic_resp_valid ? bus.mem2proc_tag  : '0;
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Counts consecutive eligible-but-denied icache cycles, saturating at the limit.
  always_comb begin
    starve_d = '0;
    if (bus.ic_req && !bus.ic_squash && !ic_grant_c) begin
      starve_d = (starve_q == CNT_W'(STARVE_LIMIT)) ? starve_q : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  assign force_ic_c = starve_q == CNT_W'(STARVE_LIMIT);
`else
  assign force_ic_c = 1'b0;
`endif

  mem_tag_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_table (
    .clk              (clk),
    .rst              (rst),
    .alloc_en_i       (alloc_en_c),
    .alloc_tag_i      (bus.mem2proc_response),
    .alloc_owner_i    (alloc_owner_c),
    .free_en_i        (ret_c),
    .free_tag_i       (bus.mem2proc_tag),
    .squash_i         (bus.ic_squash),
    .lookup_o         (lookup_c),
    .ic_outstanding_o (bus.ic_outstanding)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner-case
// sequences, then randomized traffic against a tag-ownership reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int LIMIT = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .NUM_TAGS     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        sq;
    logic        dc_req;
    BUS_COMMAND  dc_cmd;
    logic [31:0] dc_addr;
    logic [63:0] dc_wdata;
    logic [3:0]  resp;
    logic [3:0]  rtag;
    logic [63:0] rdata;
  } stim_t;

  typedef struct {
    BUS_COMMAND  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic        ic_g;
    logic        dc_g;
    logic [3:0]  gtag;
    logic        ic_rv;
    logic [63:0] ic_rd;
    logic [3:0]  ic_rt;
    logic        dc_rv;
    logic [63:0] dc_rd;
    logic [3:0]  dc_rt;
    logic [3:0]  outst;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic stim_t st(input logic icr, input logic [31:0] ica, input logic sq,
                               input logic dcr, input BUS_COMMAND dcc, input logic [31:0] dca,
                               input logic [63:0] dcw, input logic [3:0] resp,
                               input logic [3:0] rtag, input logic [63:0] rdata);
    stim_t s;
    s.ic_req = icr; s.ic_addr = ica; s.sq = sq;
    s.dc_req = dcr; s.dc_cmd = dcc; s.dc_addr = dca; s.dc_wdata = dcw;
    s.resp = resp; s.rtag = rtag; s.rdata = rdata;
    return s;
  endfunction

  function automatic exp_t ex(input BUS_COMMAND cmd, input logic [31:0] addr, input logic [63:0] data,
                              input logic icg, input logic dcg, input logic [3:0] gtag,
                              input logic icrv, input logic dcrv, input logic [3:0] rtag,
                              input logic [63:0] rdata, input logic [3:0] outst);
    exp_t e;
    e.cmd = cmd; e.addr = addr; e.data = data;
    e.ic_g = icg; e.dc_g = dcg; e.gtag = gtag;
    e.ic_rv = icrv; e.ic_rd = icrv ? rdata : 64'h0; e.ic_rt = icrv ? rtag : 4'h0;
    e.dc_rv = dcrv; e.dc_rd = dcrv ? rdata : 64'h0; e.dc_rt = dcrv ? rtag : 4'h0;
    e.outst = outst;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    bus.ic_req            = s.ic_req;
    bus.ic_addr           = s.ic_addr;
    bus.ic_squash         = s.sq;
    bus.dc_req            = s.dc_req;
    bus.dc_cmd            = s.dc_cmd;
    bus.dc_addr           = s.dc_addr;
    bus.dc_wdata          = s.dc_wdata;
    bus.mem2proc_response = s.resp;
    bus.mem2proc_tag      = s.rtag;
    bus.mem2proc_data     = s.rdata;
  endtask

  task automatic check_outs(input string nm, input exp_t e);
    chk({nm, " cmd"},   64'(bus.proc2mem_command), 64'(e.cmd));
    chk({nm, " addr"},  64'(bus.proc2mem_addr),    64'(e.addr));
    chk({nm, " data"},  bus.proc2mem_data,         e.data);
    chk({nm, " ic_g"},  64'(bus.ic_grant),         64'(e.ic_g));
    chk({nm, " dc_g"},  64'(bus.dc_grant),         64'(e.dc_g));
    if (e.ic_g || e.dc_g) chk({nm, " gtag"}, 64'(bus.grant_tag), 64'(e.gtag));
    chk({nm, " ic_rv"}, 64'(bus.ic_resp_valid),    64'(e.ic_rv));
    chk({nm, " ic_rd"}, bus.ic_resp_data,          e.ic_rd);
    chk({nm, " ic_rt"}, 64'(bus.ic_resp_tag),      64'(e.ic_rt));
    chk({nm, " dc_rv"}, 64'(bus.dc_resp_valid),    64'(e.dc_rv));
    chk({nm, " dc_rd"}, bus.dc_resp_data,          e.dc_rd);
    chk({nm, " dc_rt"}, 64'(bus.dc_resp_tag),      64'(e.dc_rt));
    chk({nm, " outst"}, 64'(bus.ic_outstanding),   64'(e.outst));
  endtask

  // Apply one cycle of inputs after the falling edge and check before the rising edge.
  task automatic apply(input string nm, input stim_t s, input exp_t e);
    @(negedge clk);
    drive(s);
    #2;
    check_outs(nm, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(st(1'b0, 32'h0, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'h0, 64'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: owner per tag (0 none, 1 icache, 2 dcache) and stale flag.
  int m_owner [16];
  bit m_stale [16];
  int m_starve;

  function automatic logic [3:0] m_count();
    int c = 0;
    for (int i = 1; i < 16; i++) if (m_owner[i] == 1 && !m_stale[i]) c++;
    return 4'(c);
  endfunction

  vec_t vecs [14];
  stim_t idle_s;

  initial begin
    rst = 1'b0;
    idle_s = st(1'b0, 32'h0, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'h0, 64'h0);
    drive(idle_s);

    vecs[0].s  = idle_s;
    vecs[0].e  = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0);
    vecs[1].s  = st(1'b1, 32'h100, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'd3, 4'h0, 64'h0);
    vecs[1].e  = ex(BUS_LOAD, 32'h100, 64'h0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0);
    vecs[2].s  = idle_s;
    vecs[2].e  = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 64'h0, 4'd1);
    vecs[3].s  = st(1'b0, 32'h0, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'd3, 64'hDEAD);
    vecs[3].e  = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd3, 64'hDEAD, 4'd1);
    vecs[4].s  = st(1'b1, 32'h140, 1'b0, 1'b1, BUS_STORE, 32'h200, 64'h55, 4'd4, 4'h0, 64'h0);
    vecs[4].e  = ex(BUS_STORE, 32'h200, 64'h55, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0);
    vecs[5].s  = st(1'b1, 32'h140, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'd5, 4'h0, 64'h0);
    vecs[5].e  = ex(BUS_LOAD, 32'h140, 64'h0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0);
    vecs[6].s  = st(1'b0, 32'h0, 1'b1, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'h0, 64'h0);
    vecs[6].e  = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 64'h0, 4'd1);
    vecs[7].s  = st(1'b0, 32'h0, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'd5, 64'hBEEF);
    vecs[7].e  = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5, 64'hBEEF, 4'd0);
    vecs[8].s  = idle_s;
    vecs[8].e  = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0);
    vecs[9].s  = st(1'b0, 32'h0, 1'b0, 1'b1, BUS_LOAD, 32'h300, 64'h0, 4'd7, 4'h0, 64'h0);
    vecs[9].e  = ex(BUS_LOAD, 32'h300, 64'h0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0);
    vecs[10].s = st(1'b1, 32'h180, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'd7, 4'd7, 64'h77);
    vecs[10].e = ex(BUS_LOAD, 32'h180, 64'h0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 4'd7, 64'h77, 4'd0);
    vecs[11].s = idle_s;
    vecs[11].e = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 64'h0, 4'd1);
    vecs[12].s = st(1'b0, 32'h0, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'd7, 64'h99);
    vecs[12].e = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd7, 64'h99, 4'd1);
    vecs[13].s = idle_s;
    vecs[13].e = ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0);

    do_reset();
    for (int v = 0; v < 14; v++) apply($sformatf("vec%0d", v), vecs[v].s, vecs[v].e);

    // Rejected request holds the bus command until memory accepts it.
    for (int k = 0; k < 3; k++) begin
      apply($sformatf("rej%0d", k), st(1'b0, 32'h0, 1'b0, 1'b1, BUS_LOAD, 32'h400, 64'h0, 4'h0, 4'h0, 64'h0),
            ex(BUS_LOAD, 32'h400, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0));
    end
    apply("rej_acc", st(1'b0, 32'h0, 1'b0, 1'b1, BUS_LOAD, 32'h400, 64'h0, 4'd9, 4'h0, 64'h0),
          ex(BUS_LOAD, 32'h400, 64'h0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0));
    apply("rej_ret", st(1'b0, 32'h0, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'd9, 64'h1234),
          ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd9, 64'h1234, 4'd0));

    // Continuous dcache stores against a held icache request.
    begin
      logic ic_on = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        logic exp_ic;
        exp_ic = ic_on && GUARD && (k == LIMIT + 1);
        apply($sformatf("starve%0d", k),
              st(ic_on, 32'h500, 1'b0, 1'b1, BUS_STORE, 32'h600, 64'hAA, 4'd11, 4'h0, 64'h0),
              ex(exp_ic ? BUS_LOAD : BUS_STORE, exp_ic ? 32'h500 : 32'h600, exp_ic ? 64'h0 : 64'hAA,
                 exp_ic, !exp_ic, 4'd11, 1'b0, 1'b0, 4'h0, 64'h0,
                 (GUARD && k > LIMIT + 1) ? 4'd1 : 4'd0));
        if (exp_ic) ic_on = 1'b0;
      end
      apply("starve_ret", st(1'b0, 32'h0, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'd11, 64'hCAFE),
            ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, GUARD, 1'b0, 4'd11, 64'hCAFE, GUARD ? 4'd1 : 4'd0));
    end

    // Reset with an icache fetch in flight; its late return must be dropped.
    apply("rst_alloc", st(1'b1, 32'h700, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'd2, 4'h0, 64'h0),
          ex(BUS_LOAD, 32'h700, 64'h0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 4'h0, 64'h0, 4'd0));
    apply("rst_pre", idle_s, ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 64'h0, 4'd1));
    do_reset();
    apply("rst_ret", st(1'b0, 32'h0, 1'b0, 1'b0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'd2, 64'h2222),
          ex(BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd2, 64'h2222, 4'd0));

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 16; i++) begin m_owner[i] = 0; m_stale[i] = 1'b0; end
    m_starve = 0;
    begin
      stim_t s;
      exp_t  e;
      bit    ic_ok, ic_wins, dc_wins, acc;
      s = idle_s;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (!s.ic_req && $urandom_range(0, 2) == 0) begin
          s.ic_req  = 1'b1;
          s.ic_addr = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255)) << 6;
        end
        if (!s.dc_req && $urandom_range(0, 3) != 0) begin
          s.dc_req   = 1'b1;
          s.dc_cmd   = ($urandom_range(0, 1) == 0) ? BUS_LOAD : BUS_STORE;
          s.dc_addr  = $urandom;
          s.dc_wdata = {$urandom, $urandom};
        end
        s.sq    = ($urandom_range(0, 9) == 0);
        s.resp  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        s.rtag  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        s.rdata = {$urandom, $urandom};

        ic_ok   = s.ic_req && !s.sq;
        ic_wins = ic_ok && (!s.dc_req || (GUARD && m_starve == LIMIT));
        dc_wins = s.dc_req && !ic_wins;
        acc     = s.resp != 4'h0;
        e = ex(ic_wins ? BUS_LOAD : (dc_wins ? s.dc_cmd : BUS_NONE),
               ic_wins ? s.ic_addr : (dc_wins ? s.dc_addr : 32'h0),
               dc_wins ? s.dc_wdata : 64'h0,
               ic_wins && acc, dc_wins && acc, s.resp,
               s.rtag != 4'h0 && m_owner[s.rtag] == 1 && !m_stale[s.rtag] && !s.sq,
               s.rtag != 4'h0 && m_owner[s.rtag] == 2,
               s.rtag, s.rdata, m_count());
        apply($sformatf("rnd%0d", cyc), s, e);

        if (s.sq) for (int t = 1; t < 16; t++) if (m_owner[t] == 1) m_stale[t] = 1'b1;
        if (s.rtag != 4'h0) begin m_owner[s.rtag] = 0; m_stale[s.rtag] = 1'b0; end
        if (e.ic_g) begin m_owner[s.resp] = 1; m_stale[s.resp] = 1'b0; end
        if (e.dc_g && s.dc_cmd == BUS_LOAD) begin m_owner[s.resp] = 2; m_stale[s.resp] = 1'b0; end
        if (!s.ic_req || s.sq || e.ic_g) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (e.ic_g) s.ic_req = 1'b0;
        if (e.dc_g) s.dc_req = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single processor-memory bus between the instruction-cache miss path and the data cache. Each cycle it selects at most one requester, drives the bus command, and on acceptance records which requester owns the returned memory tag. When tagged data comes back it routes the data to the owner. In-flight instruction fetches are discarded when fetch is redirected, so stale lines never reach the icache.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: consecutive denied icache cycles before icache is forced to win.
- `NUM_TAGS`, default 16: size of the memory tag space; tag 0 is reserved to mean "none".

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low; resets when `rst==0` at a `posedge clk`.
- `ic_req` in 1: icache miss request; held stable until granted.
- `ic_addr` in `SYS_XLEN`: icache line address.
- `ic_squash` in 1: fetch redirect.
- `dc_req` in 1: dcache request; held stable until granted.
- `dc_cmd` in `BUS_COMMAND`: `BUS_LOAD` or `BUS_STORE`.
- `dc_addr` in `SYS_XLEN`: dcache address.
- `dc_wdata` in 64: dcache store data.
- `proc2mem_command` out `BUS_COMMAND`: bus command.
- `proc2mem_addr` out `SYS_XLEN`: bus address.
- `proc2mem_data` out 64: bus store data.
- `mem2proc_response` in 4: tag of the accepted request; 0 means rejected.
- `mem2proc_data` in 64: returned data.
- `mem2proc_tag` in 4: tag of the returned data; 0 means none.
- `ic_grant` out 1: icache request accepted this cycle.
- `dc_grant` out 1: dcache request accepted this cycle.
- `grant_tag` out 4: `mem2proc_response`, valid while either grant is high.
- `ic_resp_valid` out 1, `ic_resp_data` out 64, `ic_resp_tag` out 4: icache fill.
- `dc_resp_valid` out 1, `dc_resp_data` out 64, `dc_resp_tag` out 4: dcache fill.
- `ic_outstanding` out 4: count of live (non-stale) icache tags.

## Operation
Tag table: one entry per tag 1..`NUM_TAGS`-1. Each entry holds an owner (`OWN_NONE`, `OWN_IC`, `OWN_DC`) and a `stale` bit.

Selection:
- If `ic_squash` is high, icache is not eligible this cycle.
- Otherwise dcache wins whenever it is requesting, except when the starvation guard (see Configuration) forces icache to win.

Bus drive:
- The winner's command, address and data drive the bus. Icache always issues `BUS_LOAD`.
- If there is no winner: `BUS_NONE`, address 0, data 0.

Acceptance:
- A request is accepted when `mem2proc_response != 0`. The winner's grant goes high for exactly that cycle.
- An accepted load allocates table entry `[mem2proc_response]` with owner set to the winner and `stale` cleared.
- An accepted `BUS_STORE` grants but allocates nothing.
- If `mem2proc_response == 0`, no grant is given; the requester keeps holding its request.

Return:
- When `mem2proc_tag != 0`, look up the entry for that tag:
  - Owner `OWN_DC`: assert `dc_resp_valid`.
  - Owner `OWN_IC`, not stale, and `ic_squash` low: assert `ic_resp_valid`.
  - Owner `OWN_IC` otherwise, or `OWN_NONE`: drop the data silently.
- In every case the entry is freed at the clock edge.
- Response data and tag outputs carry `mem2proc_data` and `mem2proc_tag`. They are 0 whenever the matching valid is low.

Squash: at the edge of an `ic_squash` cycle, every `OWN_IC` entry gets `stale=1`.

Simultaneous events:
- If one tag is freed by a return and reallocated by an acceptance in the same cycle, the allocation wins.
- A squash never marks an entry allocated in that same cycle. This case cannot occur anyway, because icache is ineligible during a squash.

`ic_outstanding` counts `OWN_IC` entries with `stale==0`.

## Timing
- Bus outputs, grants and response routing are combinational from the inputs and the registered table and counter. Grant latency is 0 cycles from acceptance; fill latency is 0 cycles from `mem2proc_tag`.
- The table, starvation counter and `ic_outstanding` update at `posedge clk`.
- Reset values:
  - Every combinational output becomes 0 (or `BUS_NONE`) once its inputs are idle.
  - All table entries become `OWN_NONE` with `stale=0`.
  - The starvation counter becomes 0 and `ic_outstanding` becomes 0.
- Reset in the middle of operation clears the table. Returns that arrive afterwards for pre-reset tags see `OWN_NONE` and are dropped.
- Requesters must not change request fields while their request is held and ungranted.

## Configuration
`MEM_ARB_STARVE_GUARD_EN`
- Defined:
  - A counter (width `$clog2(STARVE_LIMIT+1)`) increments on each cycle that `ic_req` is high, icache is eligible, and `ic_grant` is low.
  - It resets to 0 on `ic_grant`, on `ic_squash`, or when `ic_req` is low. It saturates at `STARVE_LIMIT`.
  - While the counter equals `STARVE_LIMIT`, icache beats dcache.
- Undefined: no counter exists; dcache has strict priority.

## Structure
- The shared package (alongside `sys_defs.svh`) holds:
  - the `MEM_OWNER` enum (`OWN_NONE`, `OWN_IC`, `OWN_DC`);
  - a `MEM_TAG_ENTRY` struct (owner, stale);
  - `MEM_NUM_TAGS`.
- `BUS_COMMAND` is reused unchanged.
- One sub-module, `mem_tag_table`, owns the entry array. It has an allocate port, a free/lookup port and a squash input, and outputs the lookup result and `ic_outstanding`.

## Test plan
- Icache only, `ic_addr=0x100`, `response=3`: `BUS_LOAD` at 0x100, `ic_grant=1`, `grant_tag=3`. A later return on tag 3 with data 0xDEAD gives `ic_resp_valid=1`, `ic_resp_data=0xDEAD`.
- Icache and dcache requesting together, dcache `BUS_STORE` 0x200: dcache granted, no table entry allocated, `ic_grant=0`. The next cycle icache is granted.
- Icache granted tag 5, then `ic_squash`, then a return on tag 5: `ic_resp_valid=0`, the entry is freed, and `ic_outstanding` goes 1 to 0.
- In one cycle, tag 7 returns for dcache while `response=7` accepts a new icache load: `dc_resp_valid=1`, and entry 7 becomes `OWN_IC`.
- With `MEM_ARB_STARVE_GUARD_EN` and `STARVE_LIMIT=8`, dcache requesting continuously: icache is granted on the 9th cycle of its request. Without the macro, icache is never granted.
- `response=0` for 3 cycles: no grant, the bus holds the same command. Reset low with tag 2 outstanding, then a return on tag 2: both resp valids stay 0.
